special_box_drawer: RTL and testbench

//  Draws up to NUM_ITEMS special-item glyphs (plus, minus, erase) into maze cells, one pixel per

---
 rtl/special_box_drawer_pkg.sv | 21 ++
 rtl/special_glyph.sv | 36 +++
 rtl/special_box_drawer.sv | 192 +++++++++++++++++++
 tb/tb_special_box_drawer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/special_box_drawer_pkg.sv
// rtl/special_box_drawer_pkg.sv - shared kind/colour encodings and FSM states for the box drawer
package special_box_drawer_pkg;

    localparam logic [1:0] KIND_PLUS  = 2'd0;
    localparam logic [1:0] KIND_MINUS = 2'd1;
    localparam logic [1:0] KIND_ERASE = 2'd2;

    localparam logic [2:0] WHITE = 3'b111;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] BLACK = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAW,
        S_NEXT,
        S_DONE
    } state_t;

endpackage

// File: rtl/special_glyph.sv
// rtl/special_glyph.sv - combinational glyph colour lookup for one box pixel
module special_glyph
    import special_box_drawer_pkg::*;
#(
    parameter int BOX_SIZE = 9,
    parameter int CNT_W    = 4
) (
    input  logic [1:0]       kind,
    input  logic [CNT_W-1:0] row,
    input  logic [CNT_W-1:0] col,
    output logic [2:0]       colour
);

    // Centre band is the middle third of the box; the outer columns frame the horizontal bar.
    localparam logic [CNT_W-1:0] BAND_LO = CNT_W'(BOX_SIZE / 3);
    localparam logic [CNT_W-1:0] BAND_HI = CNT_W'(BOX_SIZE - BOX_SIZE / 3);
    localparam logic [CNT_W-1:0] EDGE    = CNT_W'(BOX_SIZE - 1);

    logic row_band;
    logic col_band;
    logic border;

    // Classify the pixel position, then pick the colour for the glyph kind.
    always_comb begin
        row_band = (row >= BAND_LO) && (row < BAND_HI);
        col_band = (col >= BAND_LO) && (col < BAND_HI);
        border   = (col == '0) || (col == EDGE);
        colour   = BLACK;
        case (kind)
            KIND_PLUS:  colour = ((row_band && !border) || col_band) ? GREEN : WHITE;
            KIND_MINUS: colour = (row_band && !border) ? RED : WHITE;
            default:    colour = BLACK;
        endcase
    end

endmodule

// File: rtl/special_box_drawer.sv
// rtl/special_box_drawer.sv - draws enabled special-item glyphs into maze cells, one pixel per accept
module special_box_drawer
    import special_box_drawer_pkg::*;
#(
    parameter int NUM_ITEMS = 2,
    parameter int COORD_W   = 5,
    parameter int CELL_SIZE = 10,
    parameter int BOX_SIZE  = 9,
    parameter int X_OFFSET  = 80,
    parameter int Y_OFFSET  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_ITEMS*COORD_W-1:0] item_x,
    input  logic [NUM_ITEMS*COORD_W-1:0] item_y,
    input  logic [NUM_ITEMS*2-1:0]       item_kind,
    input  logic [NUM_ITEMS-1:0]         item_en,
    input  logic                         pix_ready,
    output logic [8:0]                   x_loc,
    output logic [8:0]                   y_loc,
    output logic [2:0]                   colour,
    output logic                         plot,
    output logic                         busy,
    output logic                         done
);

    localparam int IDX_W  = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
    localparam int CNT_W  = $clog2(BOX_SIZE);
    localparam int ADDR_W = 16;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BOX_SIZE - 1);

    state_t state, state_n;
    logic [IDX_W-1:0] cur, cur_n;
    logic [CNT_W-1:0] row, row_n;
    logic [CNT_W-1:0] col, col_n;

    logic [NUM_ITEMS*COORD_W-1:0] sh_x;
    logic [NUM_ITEMS*COORD_W-1:0] sh_y;
    logic [NUM_ITEMS*2-1:0]       sh_kind;
    logic [NUM_ITEMS-1:0]         sh_en;

    logic             found_lo, found_hi;
    logic [IDX_W-1:0] idx_lo, idx_hi;
    logic [COORD_W-1:0] cx, cy;
    logic [1:0]       ckind;
    logic [2:0]       glyph_colour;

    // Snapshot the item table at the accepted start so later input changes cannot disturb the pass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_x    <= '0;
            sh_y    <= '0;
            sh_kind <= '0;
            sh_en   <= '0;
        end else if (state == S_IDLE && start) begin
            sh_x    <= item_x;
            sh_y    <= item_y;
            sh_kind <= item_kind;
            sh_en   <= item_en;
        end
    end

    // Priority scan: lowest enabled slot overall, and lowest enabled slot above the current one.
    always_comb begin
        found_lo = 1'b0;
        found_hi = 1'b0;
        idx_lo   = '0;
        idx_hi   = '0;
        for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
            if (sh_en[i]) begin
                found_lo = 1'b1;
                idx_lo   = IDX_W'(i);
                if (IDX_W'(i) > cur) begin
                    found_hi = 1'b1;
                    idx_hi   = IDX_W'(i);
                end
            end
        end
    end

    // Pick out the cell coordinates and kind of the slot being drawn.
    always_comb begin
        cx    = '0;
        cy    = '0;
        ckind = KIND_ERASE;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (IDX_W'(i) == cur) begin
                cx    = sh_x[i*COORD_W +: COORD_W];
                cy    = sh_y[i*COORD_W +: COORD_W];
                ckind = sh_kind[i*2 +: 2];
            end
        end
    end

    special_glyph #(
        .BOX_SIZE (BOX_SIZE),
        .CNT_W    (CNT_W)
    ) u_glyph (
        .kind   (ckind),
        .row    (row),
        .col    (col),
        .colour (glyph_colour)
    );

    // State, slot index and pixel counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cur   <= '0;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_n;
            cur   <= cur_n;
            row   <= row_n;
            col   <= col_n;
        end
    end

    // Next-state logic; DRAW only advances on a handshake so a stalled pixel stays presented.
    always_comb begin
        state_n = state;
        cur_n   = cur;
        row_n   = row;
        col_n   = col;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                row_n = '0;
                col_n = '0;
                if (found_lo) begin
                    cur_n   = idx_lo;
                    state_n = S_DRAW;
                end else begin
                    state_n = S_DONE;
                end
            end
            S_DRAW: begin
                if (pix_ready) begin
                    if (col == LAST) begin
                        col_n = '0;
                        if (row == LAST) begin
                            state_n = S_NEXT;
                        end else begin
                            row_n = row + 1'b1;
                        end
                    end else begin
                        col_n = col + 1'b1;
                    end
                end
            end
            S_NEXT: begin
                row_n = '0;
                col_n = '0;
                if (found_hi) begin
                    cur_n   = idx_hi;
                    state_n = S_DRAW;
                end else begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                cur_n   = '0;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Output decode from registered state; pixel fields are forced to zero whenever nothing is plotted.
    always_comb begin
        plot   = (state == S_DRAW);
        busy   = (state != S_IDLE);
        done   = (state == S_DONE);
        x_loc  = '0;
        y_loc  = '0;
        colour = '0;
        if (plot) begin
            x_loc  = 9'(ADDR_W'(X_OFFSET) + ADDR_W'(cx) * ADDR_W'(CELL_SIZE) + ADDR_W'(col));
            y_loc  = 9'(ADDR_W'(Y_OFFSET) + ADDR_W'(cy) * ADDR_W'(CELL_SIZE) + ADDR_W'(row));
            colour = glyph_colour;
        end
    end

endmodule

// File: tb/tb_special_box_drawer.sv
// tb/tb_special_box_drawer.sv - self-checking bench for special_box_drawer
module tb_special_box_drawer;

    typedef struct {
        logic [1:0] en;
        logic [4:0] x0;
        logic [4:0] y0;
        logic [1:0] k0;
        logic [4:0] x1;
        logic [4:0] y1;
        logic [1:0] k1;
    } cfg_t;

    typedef struct {
        cfg_t c;
        int plots;
        int cycles;
        int fx, fy, fc;
        int lx, ly, lc;
        int p0_idx, p0_col;
        int p1_idx, p1_col;
    } vec_t;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    localparam int LIMIT = 3000;

    logic       clk;
    logic       reset;
    logic       start;
    logic [9:0] item_x;
    logic [9:0] item_y;
    logic [3:0] item_kind;
    logic [1:0] item_en;
    logic       pix_ready;
    logic [8:0] x_loc;
    logic [8:0] y_loc;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_bad = 0;

    pix_t exp_q[$];
    pix_t got_q[$];
    vec_t vt[6];

    special_box_drawer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .item_x    (item_x),
        .item_y    (item_y),
        .item_kind (item_kind),
        .item_en   (item_en),
        .pix_ready (pix_ready),
        .x_loc     (x_loc),
        .y_loc     (y_loc),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Glyph rules for a 9x9 box: band is rows/cols 3..5, border columns are 0 and 8.
    function automatic int glyph(input int kind, input int r, input int c);
        bit rb, cb, bd;
        rb = (r >= 9 / 3) && (r < 9 - 9 / 3);
        cb = (c >= 9 / 3) && (c < 9 - 9 / 3);
        bd = (c == 0) || (c == 8);
        if (kind == 0) return ((rb && !bd) || cb) ? 2 : 7;
        if (kind == 1) return (rb && !bd) ? 4 : 7;
        return 0;
    endfunction

    // Expected pixel stream: enabled slots in ascending order, raster order within each box.
    task automatic build_model(input cfg_t c);
        int xs[2], ys[2], ks[2];
        exp_q.delete();
        xs[0] = c.x0; ys[0] = c.y0; ks[0] = c.k0;
        xs[1] = c.x1; ys[1] = c.y1; ks[1] = c.k1;
        for (int s = 0; s < 2; s++) begin
            if (c.en[s]) begin
                for (int r = 0; r < 9; r++) begin
                    for (int cc = 0; cc < 9; cc++) begin
                        pix_t p;
                        p.x = (80 + xs[s] * 10 + cc) % 512;
                        p.y = (0 + ys[s] * 10 + r) % 512;
                        p.c = glyph(ks[s], r, cc);
                        exp_q.push_back(p);
                    end
                end
            end
        end
    endtask

    task automatic apply_cfg(input cfg_t c);
        item_x    = {c.x1, c.x0};
        item_y    = {c.y1, c.y0};
        item_kind = {c.k1, c.k0};
        item_en   = c.en;
    endtask

    // One full pass; rnd enables random back-pressure, stray start pulses and input scrambling.
    task automatic do_pass(input cfg_t c, input bit rnd, output int plots, output int cycles);
        int  done_cnt;
        bit  finished;
        build_model(c);
        got_q.delete();
        @(negedge clk);
        apply_cfg(c);
        start     = 1'b1;
        pix_ready = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cycles   = 0;
        plots    = 0;
        done_cnt = 0;
        finished = 1'b0;
        for (int t = 0; t < LIMIT && !finished; t++) begin
            if (rnd) begin
                pix_ready = ($urandom_range(0, 9) < 6);
                item_x    = 10'($urandom);
                item_y    = 10'($urandom);
                item_kind = 4'($urandom);
                item_en   = 2'($urandom);
            end
            if (busy) cycles++;
            if (!plot) begin
                chk("idle_pixel_zero", {x_loc, y_loc, colour}, 0);
            end else if (exp_q.size() == 0) begin
                chk("extra_plot", 1, 0);
            end else begin
                chk("pix_x", x_loc, exp_q[0].x);
                chk("pix_y", y_loc, exp_q[0].y);
                chk("pix_colour", colour, exp_q[0].c);
                if (pix_ready) begin
                    pix_t p;
                    p.x = x_loc;
                    p.y = y_loc;
                    p.c = colour;
                    got_q.push_back(p);
                    void'(exp_q.pop_front());
                    plots++;
                end
            end
            if (done) begin
                done_cnt++;
                chk("busy_with_done", busy, 1);
            end
            if (!busy) begin
                finished = 1'b1;
                start    = 1'b0;
            end else begin
                if (rnd) start = ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk("pass_finished", finished, 1);
        chk("done_pulses", done_cnt, 1);
        chk("pixels_left", exp_q.size(), 0);
    endtask

    initial begin
        int plots, cycles;
        cfg_t c;

        vt[0] = '{'{2'b01, 5'd3, 5'd2, 2'd0, 5'd0, 5'd0, 2'd0}, 81, 84, 110, 20, 7, 118, 28, 7, 4, 2, 36, 7};
        vt[1] = '{'{2'b11, 5'd0, 5'd0, 2'd0, 5'd1, 5'd0, 2'd1}, 162, 166, 80, 0, 7, 98, 8, 7, 109, 4, 108, 7};
        vt[2] = '{'{2'b00, 5'd3, 5'd3, 2'd0, 5'd4, 5'd4, 2'd1}, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[3] = '{'{2'b01, 5'd31, 5'd31, 2'd2, 5'd0, 5'd0, 2'd0}, 81, 84, 390, 310, 0, 398, 318, 0, 40, 0, 80, 0};
        vt[4] = '{'{2'b10, 5'd7, 5'd7, 2'd0, 5'd2, 5'd5, 2'd1}, 81, 84, 100, 50, 7, 108, 58, 7, 40, 4, 37, 4};
        vt[5] = '{'{2'b11, 5'd4, 5'd4, 2'd0, 5'd4, 5'd4, 2'd3}, 162, 166, 120, 40, 7, 128, 48, 0, 40, 2, 121, 0};

        reset     = 1'b1;
        start     = 1'b0;
        pix_ready = 1'b1;
        item_x    = '0;
        item_y    = '0;
        item_kind = '0;
        item_en   = '0;
        #12;
        chk("reset_plot", plot, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_pixel", {x_loc, y_loc, colour}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors with pix_ready held high.
        for (int v = 0; v < 6; v++) begin
            do_pass(vt[v].c, 1'b0, plots, cycles);
            chk($sformatf("v%0d_plots", v), plots, vt[v].plots);
            chk($sformatf("v%0d_cycles", v), cycles, vt[v].cycles);
            if (vt[v].plots > 0 && got_q.size() == vt[v].plots) begin
                chk($sformatf("v%0d_first_x", v), got_q[0].x, vt[v].fx);
                chk($sformatf("v%0d_first_y", v), got_q[0].y, vt[v].fy);
                chk($sformatf("v%0d_first_c", v), got_q[0].c, vt[v].fc);
                chk($sformatf("v%0d_last_x", v), got_q[vt[v].plots-1].x, vt[v].lx);
                chk($sformatf("v%0d_last_y", v), got_q[vt[v].plots-1].y, vt[v].ly);
                chk($sformatf("v%0d_last_c", v), got_q[vt[v].plots-1].c, vt[v].lc);
                chk($sformatf("v%0d_probe0", v), got_q[vt[v].p0_idx].c, vt[v].p0_col);
                chk($sformatf("v%0d_probe1", v), got_q[vt[v].p1_idx].c, vt[v].p1_col);
            end
        end

        // Reset mid-DRAW at slot 0 row 4, then a clean redraw.
        @(negedge clk);
        apply_cfg(vt[0].c);
        start     = 1'b1;
        pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (37) @(negedge clk);
        chk("mid_plot", plot, 1);
        chk("mid_x", x_loc, 110);
        chk("mid_y", y_loc, 24);
        #2 reset = 1'b1;
        #1;
        chk("abort_plot", plot, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pixel", {x_loc, y_loc, colour}, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_abort_quiet", {busy, done, plot}, 0);
        end
        do_pass(vt[0].c, 1'b0, plots, cycles);
        chk("redraw_plots", plots, 81);
        chk("redraw_cycles", cycles, 84);

        // Random configurations with random back-pressure and stray inputs during the pass.
        for (int n = 0; n < 12; n++) begin
            int k;
            c.en = 2'($urandom);
            c.x0 = 5'($urandom);
            c.y0 = 5'($urandom);
            c.k0 = 2'($urandom);
            c.x1 = 5'($urandom);
            c.y1 = 5'($urandom);
            c.k1 = 2'($urandom);
            k = int'(c.en[0]) + int'(c.en[1]);
            do_pass(c, 1'b1, plots, cycles);
            chk("rand_plots", plots, k * 81);
        end

        repeat (3) @(negedge clk);
        chk("final_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
